// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle main control unit: opcodes,
// state codes, and the datapath control encodings.
package mc_control_fsm_pkg;

  localparam int OPW  = 6;
  localparam int IOPW = 3;

  // instr[31:26] values the controller recognises
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // 4-bit state encoding
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR = 4'd3;
  localparam logic [3:0] ST_MEM_RD   = 4'd4;
  localparam logic [3:0] ST_MEM_WB   = 4'd5;
  localparam logic [3:0] ST_MEM_WR   = 4'd6;
  localparam logic [3:0] ST_EXEC_R   = 4'd7;
  localparam logic [3:0] ST_ALU_WB_R = 4'd8;
  localparam logic [3:0] ST_EXEC_I   = 4'd9;
  localparam logic [3:0] ST_ALU_WB_I = 4'd10;
  localparam logic [3:0] ST_BRANCH   = 4'd11;
  localparam logic [3:0] ST_JUMP     = 4'd12;

  // ALUOp codes, shared with the ALU op decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IOP   = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_control_word.sv
// Combinational map from controller state (plus mem_ready) to the
// datapath control bundle. Anything a state does not drive stays 0.
module mc_control_word
  import mc_control_fsm_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Moore decode; mem_ready only gates the completing strobes of memory states
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      ST_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB_R: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_IOP;
      end
      ST_ALU_WB_I: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main control unit: state register, next-state logic and the
// i_op latch feeding the ALU op decoder.
//
// state    | meaning
// IDLE     | out of reset, all enables low
// FETCH    | read instruction at PC, PC+4 (waits on mem_ready)
// DECODE   | branch target precompute, latch i_op, dispatch on opcode
// MEM_ADDR | rs + sign-ext imm for lw/sw
// MEM_RD   | data read (waits on mem_ready)
// MEM_WB   | MDR -> rt
// MEM_WR   | data write (waits on mem_ready)
// EXEC_R   | R-type ALU op by funct
// ALU_WB_R | ALUOut -> rd
// EXEC_I   | I-type ALU op by i_op
// ALU_WB_I | ALUOut -> rt
// BRANCH   | beq compare and conditional PC load
// JUMP     | PC <- jump target
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int IOPW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic [1:0]      ALUOp,
  output logic [IOPW-1:0] i_op,
  output logic            instr_done,
  output logic            illegal
);

  logic [3:0]      state_q, state_d;
  logic [IOPW-1:0] i_op_q;
  logic            is_store_q;
  logic            bad_op;
  ctrl_t           ctrl;

  // Next-state selection; unsupported opcodes abort back to FETCH from DECODE
  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                                      state_d = ST_EXEC_R;
          OP_LW, OP_SW:                                  state_d = ST_MEM_ADDR;
          OP_BEQ:                                        state_d = ST_BRANCH;
          OP_J:                                          state_d = ST_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:    state_d = ST_EXEC_I;
          default: begin
            state_d = ST_FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: state_d = is_store_q ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_EXEC_R:   state_d = ST_ALU_WB_R;
      ST_ALU_WB_R: state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_ALU_WB_I;
      ST_ALU_WB_I: state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture i_op and the lw/sw distinction while the opcode is decoded, so
  // later states do not depend on the IR staying untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_op_q     <= '0;
      is_store_q <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      i_op_q     <= opcode[IOPW-1:0];
      is_store_q <= (opcode == OP_SW);
    end
  end

  mc_control_word u_control_word (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign i_op        = i_op_q;
  assign illegal     = bad_op;
  assign instr_done  = ctrl.instr_done | bad_op;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for the multicycle main control unit: randomized instruction stream
// checked cycle by cycle against an instruction-level expectation builder,
// plus directed reset and latency cases.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [2:0] i_op;
  logic       instr_done, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .i_op(i_op), .instr_done(instr_done), .illegal(illegal)
  );

  logic [20:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                ALUOp, instr_done, illegal, i_op};

  typedef struct packed {
    logic        mr;
    logic [20:0] exp;
  } step_t;

  step_t      q[$];
  logic [2:0] cur_iop;

  logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000010, 6'b001000, 6'b001100, 6'b001101,
                                 6'b001110, 6'b001010};

  // expected output vector, fields in obs order
  function automatic logic [20:0] cv(int pcw, int pcwc, int iord, int mrd,
                                     int mwr, int irw, int m2r, int rdst,
                                     int rw, int asa, int asb, int pcs,
                                     int aop, int done, int ill, logic [2:0] iop);
    return {pcw[0], pcwc[0], iord[0], mrd[0], mwr[0], irw[0], m2r[0], rdst[0],
            rw[0], asa[0], asb[1:0], pcs[1:0], aop[1:0], done[0], ill[0], iop};
  endfunction

  // 0=R 1=lw 2=sw 3=beq 4=j 5=I-type ALU 6=unsupported
  function automatic int op_class(logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b000010: return 4;
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: return 5;
      default:   return 6;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic dc();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle behaviour of one instruction, starting in FETCH
  task automatic build(logic [5:0] op, int fstall, int mstall);
    int         cls;
    logic [2:0] ni;
    cls = op_class(op);
    ni  = op[2:0];
    for (int i = 0; i < fstall; i++)
      q.push_back('{1'b0, cv(0,0,0,1,0,0,0,0,0,0,1,0,0,0,0,cur_iop)});
    q.push_back('{1'b1, cv(1,0,0,1,0,1,0,0,0,0,1,0,0,0,0,cur_iop)});
    q.push_back('{dc(), cv(0,0,0,0,0,0,0,0,0,0,3,0,0,(cls==6),(cls==6),cur_iop)});
    case (cls)
      0: begin
        q.push_back('{dc(), cv(0,0,0,0,0,0,0,0,0,1,0,0,2,0,0,ni)});
        q.push_back('{dc(), cv(0,0,0,0,0,0,0,1,1,0,0,0,0,1,0,ni)});
      end
      1: begin
        q.push_back('{dc(), cv(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0,ni)});
        for (int i = 0; i < mstall; i++)
          q.push_back('{1'b0, cv(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,ni)});
        q.push_back('{1'b1, cv(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,ni)});
        q.push_back('{dc(), cv(0,0,0,0,0,0,1,0,1,0,0,0,0,1,0,ni)});
      end
      2: begin
        q.push_back('{dc(), cv(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0,ni)});
        for (int i = 0; i < mstall; i++)
          q.push_back('{1'b0, cv(0,0,1,0,1,0,0,0,0,0,0,0,0,0,0,ni)});
        q.push_back('{1'b1, cv(0,0,1,0,1,0,0,0,0,0,0,0,0,1,0,ni)});
      end
      3: q.push_back('{dc(), cv(0,1,0,0,0,0,0,0,0,1,0,1,1,1,0,ni)});
      4: q.push_back('{dc(), cv(1,0,0,0,0,0,0,0,0,0,0,2,0,1,0,ni)});
      5: begin
        q.push_back('{dc(), cv(0,0,0,0,0,0,0,0,0,1,2,0,3,0,0,ni)});
        q.push_back('{dc(), cv(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0,ni)});
      end
      default: ;
    endcase
    cur_iop = ni;
  endtask

  // Drive and check one instruction; entered and left at posedge+1 in FETCH
  task automatic run_instr(string tag, logic [5:0] op, int fstall, int mstall);
    step_t s;
    q.delete();
    build(op, fstall, mstall);
    opcode = op;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.mr;
      @(negedge clk);
      chk(tag, 32'(obs), 32'(s.exp));
      chk("rd_wr_exclusive", 32'(MemRead & MemWrite), 32'd0);
      chk("rw_pc_exclusive", 32'(RegWrite & (PCWrite | PCWriteCond)), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Count cycles from FETCH to instr_done, stalling each memory access
  task automatic count_cycles(string tag, logic [5:0] op, int stall, int exp);
    int   cyc;
    int   rem;
    logic done;
    cyc  = 0;
    rem  = stall;
    done = 1'b0;
    opcode = op;
    while (!done && cyc < 60) begin
      if (MemRead | MemWrite) begin
        if (rem > 0) begin
          mem_ready = 1'b0;
          rem--;
        end else begin
          mem_ready = 1'b1;
          rem = stall;
        end
      end else begin
        mem_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
      done = instr_done;
      @(posedge clk);
      #1;
    end
    chk(tag, 32'(cyc), 32'(exp));
    cur_iop = op[2:0];
  endtask

  initial begin
    logic [5:0] op;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'b0;
    cur_iop   = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    chk("first_fetch_memread", 32'(MemRead), 32'd1);

    // directed: add, ori, lw with stalls, sw, beq, j, unsupported opcode
    run_instr("add", 6'b000000, 0, 0);
    run_instr("ori", 6'b001101, 0, 0);
    run_instr("lw_stall", 6'b100011, 3, 3);
    run_instr("sw_stall", 6'b101011, 2, 1);
    run_instr("beq", 6'b000100, 0, 0);
    run_instr("j", 6'b000010, 0, 0);
    run_instr("illegal", 6'b111111, 0, 0);

    count_cycles("cyc_add", 6'b000000, 0, 4);
    count_cycles("cyc_addi", 6'b001000, 0, 4);
    count_cycles("cyc_lw", 6'b100011, 0, 5);
    count_cycles("cyc_sw", 6'b101011, 0, 4);
    count_cycles("cyc_beq", 6'b000100, 0, 3);
    count_cycles("cyc_j", 6'b000010, 0, 3);
    count_cycles("cyc_lw_stall3", 6'b100011, 3, 11);
    count_cycles("cyc_illegal", 6'b111111, 0, 2);

    // reset in the middle of an R-type execute
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("exec_r_aluop", 32'(ALUOp), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    chk("held_reset_outputs", 32'(obs), 32'd0);
    rst_n = 1'b1;
    cur_iop = 3'b000;
    @(negedge clk);
    chk("post_reset_idle", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    chk("post_reset_fetch", 32'(MemRead), 32'd1);

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 9)];
      else                           op = 6'($urandom);
      run_instr("rand_instr", op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
